// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-addressed data memory port.
// Sub-word stores are built as read-modify-write of the word at addr.
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic [32:0] nbytes;
    logic [32:0] end_addr;
    logic        req_err;

    always_comb begin
        nbytes = 33'd4;
        unique case (req_size_i)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        end_addr = {1'b0, req_addr_i} + nbytes;
        req_err  = (req_size_i == 2'b11) || (end_addr > 33'(MEM_BYTES));
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] r;
        unique case (sz)
            2'b00:   r = {{24{~uns & w[7]}}, w[7:0]};
            2'b01:   r = {{16{~uns & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [15:0] wd,
                                          input logic [1:0] sz);
        return (sz == 2'b00) ? {old[31:8], wd[7:0]} : {old[31:16], wd};
    endfunction

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid_i) begin
                    size_q      <= req_size_i;
                    uns_q       <= req_unsigned_i;
                    addr_q      <= req_addr_i;
                    wdata_q     <= req_wdata_i[15:0];
                    req_ready_o <= 1'b0;
                    if (req_err) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                    end else if (!req_we_i) begin
                        state      <= RD;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= req_addr_i;
                    end else if (req_size_i == 2'b10) begin
                        state       <= WR;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= req_addr_i;
                        mem_wdata_o <= req_wdata_i;
                    end else begin
                        state      <= RMW_RD;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= req_addr_i;
                    end
                end
                RD: begin
                    state        <= RESP;
                    mem_read_o   <= 1'b0;
                    mem_addr_o   <= '0;
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= load_ext(mem_rdata_i, size_q, uns_q);
                end
                RMW_RD: begin
                    state       <= WR;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b1;
                    mem_addr_o  <= addr_q;
                    mem_wdata_o <= merge(mem_rdata_i, wdata_q, size_q);
                end
                WR: begin
                    state        <= RESP;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= '0;
                    mem_wdata_o  <= '0;
                    resp_valid_o <= 1'b1;
                end
                RESP: if (resp_ready_i) begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_rdata_o <= '0;
                    resp_err_o   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a byte-array memory model.
// Expected results come from a separate reference byte array.
module tb_lsu_mem_master;

    localparam int MB = 32;

    logic        clk_i = 0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] mem_rdata_i;

    logic [7:0] mem [0:MB-1];
    logic [7:0] refm [0:MB-1];

    int n_vec = 0;
    int n_bad = 0;

    lsu_mem_master #(.MEM_BYTES(MB)) dut (
        .clk_i(clk_i), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_write_o(mem_write_o),
        .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        mem_rdata_i = '0;
        for (int k = 0; k < 4; k++)
            if ({1'b0, mem_addr_o} + 33'(k) < 33'(MB))
                mem_rdata_i[8*k +: 8] = mem[mem_addr_o[4:0] + 5'(k)];
    end

    always @(posedge clk_i)
        if (mem_write_o)
            for (int k = 0; k < 4; k++)
                if ({1'b0, mem_addr_o} + 33'(k) < 33'(MB))
                    mem[mem_addr_o[4:0] + 5'(k)] <= mem_wdata_o[8*k +: 8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        mem[a]  = b;
        refm[a] = b;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
        longint      nb;
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] held;
        int          e_lat, e_wr, e_rdn, lat, wr, rdn;
        nb    = longint'(1) << sz;
        e_err = (sz == 2'b11) || (longint'(a) + nb > MB);
        e_rd  = 0;
        e_wr  = 0;
        e_rdn = 0;
        if (e_err) e_lat = 1;
        else if (!we) begin
            e_lat = 2;
            e_rdn = 1;
            for (int k = 0; k < nb; k++) e_rd |= 32'(refm[a + k]) << (8 * k);
            if (!uns && sz == 0 && e_rd[7])  e_rd |= 32'hFFFFFF00;
            if (!uns && sz == 1 && e_rd[15]) e_rd |= 32'hFFFF0000;
        end else begin
            e_lat = (sz == 2'b10) ? 2 : 3;
            e_rdn = (sz == 2'b10) ? 0 : 1;
            e_wr  = 1;
            for (int k = 0; k < nb; k++) refm[a + k] = wd[8*k +: 8];
        end
        @(negedge clk_i);
        chk("req_ready_idle", 32'(req_ready_o), 1);
        req_valid_i = 1; req_we_i = we; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
        resp_ready_i = 0;
        @(posedge clk_i); #1;
        req_valid_i = $urandom_range(0, 1);
        req_we_i = $urandom_range(0, 1);
        req_addr_i = $urandom;
        req_wdata_i = $urandom;
        lat = 1; wr = 0; rdn = 0;
        while (!resp_valid_o && lat < 10) begin
            if (mem_write_o) wr++;
            if (mem_read_o) rdn++;
            if (mem_write_o && mem_read_o) chk("rd_wr_both", 1, 0);
            if (req_ready_o) chk("ready_busy", 1, 0);
            @(posedge clk_i); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("writes", 32'(wr), 32'(e_wr));
        chk("reads", 32'(rdn), 32'(e_rdn));
        chk("err", 32'(resp_err_o), 32'(e_err));
        chk("rdata", resp_rdata_o, e_rd);
        held = resp_rdata_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk("hold_valid", 32'(resp_valid_o), 1);
            chk("hold_ready", 32'(req_ready_o), 0);
            chk("hold_data", resp_rdata_o, held);
            if (mem_write_o || mem_read_o) chk("hold_strobe", 1, 0);
        end
        @(negedge clk_i);
        req_valid_i = 0;
        resp_ready_i = 1;
        @(posedge clk_i); #1;
        resp_ready_i = 0;
        chk("post_valid", 32'(resp_valid_o), 0);
        chk("post_ready", 32'(req_ready_o), 1);
        chk("post_rdata", resp_rdata_o, 0);
    endtask

    task automatic mem_cmp(input string tag);
        for (int i = 0; i < MB; i++) chk(tag, 32'(mem[i]), 32'(refm[i]));
    endtask

    initial begin
        reset = 1;
        req_valid_i = 0; req_we_i = 0; req_size_i = 0;
        req_unsigned_i = 0; req_addr_i = 0; req_wdata_i = 0;
        resp_ready_i = 0;
        for (int i = 0; i < MB; i++) poke(i, 8'($urandom));
        #1;
        chk("rst_ready", 32'(req_ready_o), 1);
        chk("rst_valid", 32'(resp_valid_o), 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_strobes", {30'd0, mem_write_o, mem_read_o}, 0);
        chk("rst_addr", mem_addr_o, 0);
        @(negedge clk_i); @(negedge clk_i);
        reset = 0;

        poke(4, 8'h7F); poke(5, 8'h80);
        xact(0, 2'b00, 0, 5, 0, 0);
        xact(0, 2'b00, 1, 5, 0, 0);
        xact(0, 2'b01, 0, 4, 0, 0);
        poke(4, 8'h44); poke(5, 8'h33); poke(6, 8'h22); poke(7, 8'h11);
        xact(1, 2'b00, 0, 4, 32'h000000AA, 0);
        xact(0, 2'b10, 0, 4, 0, 0);
        chk("rmw_word", resp_rdata_o === 0 ? {mem[7], mem[6], mem[5], mem[4]} : 0,
            32'h112233AA);
        xact(1, 2'b10, 0, 28, 32'hDEADBEEF, 0);
        xact(0, 2'b10, 0, 28, 0, 0);
        xact(1, 2'b10, 0, 29, 32'h12345678, 0);
        xact(0, 2'b01, 0, 31, 0, 0);
        xact(1, 2'b11, 0, 0, 32'h1, 0);
        xact(0, 2'b11, 1, 8, 0, 0);
        xact(0, 2'b10, 0, 12, 0, 3);
        xact(0, 2'b00, 0, 31, 0, 0);
        xact(1, 2'b01, 0, 30, 32'hCAFEBABE, 1);
        mem_cmp("mem_directed");

        // reset during the write cycle of a byte store must not touch memory
        @(negedge clk_i);
        req_valid_i = 1; req_we_i = 1; req_size_i = 0;
        req_addr_i = 8; req_wdata_i = 32'h5A;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        @(posedge clk_i); #1;
        chk("wr_phase", 32'(mem_write_o), 1);
        reset = 1;
        #1;
        chk("async_wr_drop", 32'(mem_write_o), 0);
        chk("async_rd_drop", 32'(mem_read_o), 0);
        @(posedge clk_i); #1;
        mem_cmp("mem_after_rst");
        @(negedge clk_i);
        reset = 0;
        #1;
        chk("rel_ready", 32'(req_ready_o), 1);
        chk("rel_valid", 32'(resp_valid_o), 0);
        xact(0, 2'b10, 0, 8, 0, 0);

        for (int t = 0; t < 300; t++)
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 35)),
                 $urandom, $urandom_range(0, 3));
        xact(0, 2'b10, 0, 32'hFFFFFFFE, 0, 0);
        mem_cmp("mem_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the byte-addressed data memory port (addr/wdata/MemWrite/MemRead/rdata) on behalf of the core.
- Accepts byte, half and word requests through a valid/ready handshake.
- Builds sub-word stores as read-modify-write over the word-wide memory port, and sign- or zero-extends sub-word loads.
- Range-checks every access and returns the result on a response handshake.

Parameters:
- MEM_BYTES, 32, memory size in bytes; used for the range check.

Ports:
- clk_i  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  block can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  input  1  load zero-extend (1) or sign-extend (0)
- req_addr_i  input  32  byte address; unaligned allowed
- req_wdata_i  input  32  store data, right-justified
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  consumer accepts response
- resp_rdata_o  output  32  extended load data; 0 for stores and errors
- resp_err_o  output  1  access rejected
- mem_addr_o  output  32  memory byte address
- mem_wdata_o  output  32  memory write word
- mem_write_o  output  1  memory write strobe
- mem_read_o  output  1  memory read enable
- mem_rdata_i  input  32  memory read word; combinational from mem_addr_o

Behaviour:
- Clock is clk_i; reset is asynchronous and active-high.
- Reset values: state IDLE, req_ready_o=1; all other outputs 0; latched request cleared.
- Reset mid-operation: the transaction is dropped and mem_write_o/mem_read_o fall immediately (asynchronously). No partial write may occur after reset assertion.
- States: IDLE, RD, RMW_RD, WR, RESP.
- req_ready_o=1 only in IDLE. Accept = req_valid_i & req_ready_o.
  - On accept, latch we, size, unsigned, addr and wdata.
  - Inputs are ignored outside IDLE.
- Error check, done at accept:
  - size==11, or addr+nbytes > MEM_BYTES (computed in 33 bits, no wrap).
  - nbytes is 1, 2 or 4 by size.
  - Error goes directly to RESP with resp_err_o=1, resp_rdata_o=0 and no memory strobe at any time.
- Next state from IDLE on a legal accept:
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD:
  - Drives mem_addr_o=addr, mem_read_o=1.
  - Captures mem_rdata_i at the clock edge.
  - Extension: byte uses [7:0], half uses [15:0], each sign- or zero-extended by the unsigned flag; word is raw.
  - Goes to RESP.
- RMW_RD:
  - Drives mem_read_o=1 at addr and captures the old word.
  - Merges the new data: byte replaces [7:0], half replaces [15:0], upper bits are kept.
  - Goes to WR.
- WR:
  - Drives mem_addr_o=addr, mem_wdata_o = merged word (or raw wdata for word stores), mem_write_o=1 for exactly one cycle.
  - Goes to RESP.
- RESP:
  - resp_valid_o=1 with resp_rdata_o and resp_err_o stable.
  - Held until resp_ready_i=1, then IDLE on that edge.
  - Fields are 0 whenever resp_valid_o=0.
- Outside RD/RMW_RD/WR: mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
- mem_read_o and mem_write_o are never high in the same cycle.
- Latency (accept edge = cycle 0), resp_valid_o first high:
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- Back-to-back throughput: the next accept is possible the cycle after the response handshake, when IDLE is re-entered.

Test Plan:
- Memory byte 5 = 0x80; load byte signed at addr 5 -> resp_rdata_o=0xFFFFFF80 at cycle 2; unsigned -> 0x00000080; half signed at 4 with bytes 4..5 = 0x7F,0x80 -> 0xFFFF807F.
- Word at 4 = 0x11223344; store byte 0xAA at addr 4 -> RMW_RD at cycle 1, mem_write_o high only in cycle 2 with mem_wdata_o=0x112233AA; response at cycle 3, err 0.
- Store word 0xDEADBEEF at addr 28 then load word at 28 -> response 0xDEADBEEF, err 0.
- Store word at addr 29, load half at addr 31, and any size=11 request -> resp_err_o=1 at cycle 1, resp_rdata_o=0, mem_read_o and mem_write_o never asserted.
- Load with resp_ready_i held low 3 cycles -> resp_valid_o and data stable for 4 cycles, req_ready_o=0 throughout; back in IDLE after the handshake.
- Assert reset during the WR cycle of a byte store -> mem_write_o falls asynchronously and the memory word is unchanged. After release: req_ready_o=1, resp_valid_o=0, and a new load completes normally.
